// File: rtl/diff_window_accumulator.sv
// -----------------------------------------------------------------------------
// diff_window_accumulator
//
// Accumulates a stream of two's-complement differences (from the subtractor
// stage) over a frame of FRAME_LEN samples, or fewer when the frame is flushed
// early. Each closed frame is presented once as a saturated sum, a sample count
// and a sticky overflow flag over a valid/ready output. The frame result is
// held in HOLD until downstream takes it; input is stalled meanwhile.
//
// Optional build macro:
//   DIFF_ACC_ABS_EN  - each sample contributes |io_in_bits|, so the frame
//                      result is a sum of absolute differences (non-negative,
//                      saturates to the positive maximum only).
//
// Ports:
//   clock         in   rising-edge clock
//   reset         in   asynchronous active-low reset
//   io_in_valid   in   difference sample valid
//   io_in_ready   out  block can accept a sample (low in HOLD)
//   io_in_bits    in   WIDTH-bit signed difference
//   io_flush      in   close the current frame early
//   io_out_valid  out  frame result valid
//   io_out_ready  in   downstream accepts the result
//   io_out_sum    out  ACC_WIDTH-bit signed saturated frame sum
//   io_out_count  out  number of samples in the frame
//   io_out_ovf    out  saturation occurred in this frame
// -----------------------------------------------------------------------------
module diff_window_accumulator #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 24,
    parameter int FRAME_LEN = 8,
    // Derived from FRAME_LEN; not meant to be overridden.
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_in_valid,
    output logic                 io_in_ready,
    input  logic [WIDTH-1:0]     io_in_bits,
    input  logic                 io_flush,
    output logic                 io_out_valid,
    input  logic                 io_out_ready,
    output logic [ACC_WIDTH-1:0] io_out_sum,
    output logic [CNT_W-1:0]     io_out_count,
    output logic                 io_out_ovf
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [ACC_WIDTH-1:0] ACC_ZERO = {ACC_WIDTH{1'b0}};
    localparam logic [CNT_W-1:0]     CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(FRAME_LEN);

    // Widen one sample to ACC_WIDTH+1 bits, the width of the unclamped sum.
    function automatic logic [ACC_WIDTH:0] extend_sample(input logic [WIDTH-1:0] s);
        logic [WIDTH:0] mag;
`ifdef DIFF_ACC_ABS_EN
        // Negation of the sign-extended value; the extra bit keeps
        // |-2^(WIDTH-1)| exact.
        if (s[WIDTH-1]) begin
            mag = {1'b0, ~s} + {{WIDTH{1'b0}}, 1'b1};
        end else begin
            mag = {1'b0, s};
        end
        return {{(ACC_WIDTH-WIDTH){1'b0}}, mag};
`else
        mag = {s[WIDTH-1], s};
        return {{(ACC_WIDTH-WIDTH){mag[WIDTH]}}, mag};
`endif
    endfunction

    // Clamp an ACC_WIDTH+1-bit sum into ACC_WIDTH bits; MSB of the result is
    // the clamp flag. The top two bits differing means the value left range.
    function automatic logic [ACC_WIDTH:0] saturate(input logic [ACC_WIDTH:0] sum);
        logic [ACC_WIDTH:0] ret;
        if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
            if (sum[ACC_WIDTH]) begin
                ret = {1'b1, ACC_MIN};
            end else begin
                ret = {1'b1, ACC_MAX};
            end
        end else begin
            ret = {1'b0, sum[ACC_WIDTH-1:0]};
        end
        return ret;
    endfunction

    logic [1:0]           state_r;
    logic [ACC_WIDTH-1:0] acc_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 ovf_r;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic [ACC_WIDTH-1:0] out_sum_r;
    logic [CNT_W-1:0]     out_count_r;
    logic                 out_ovf_r;

    logic                 accept_s;
    logic [ACC_WIDTH-1:0] base_s;
    logic [ACC_WIDTH:0]   sum_s;
    logic [ACC_WIDTH:0]   sat_s;
    logic                 clamp_s;
    logic [ACC_WIDTH-1:0] acc_add_s;
    logic [CNT_W-1:0]     cnt_inc_s;

    logic [1:0]           state_nxt_s;
    logic [ACC_WIDTH-1:0] acc_nxt_s;
    logic [CNT_W-1:0]     cnt_nxt_s;
    logic                 ovf_nxt_s;
    logic                 close_s;

    assign accept_s = io_in_valid & (state_r != ST_HOLD);

    // Saturating add of the incoming sample; a fresh frame starts from zero.
    always_comb begin
        if (state_r == ST_IDLE) begin
            base_s = ACC_ZERO;
        end else begin
            base_s = acc_r;
        end
        sum_s     = {base_s[ACC_WIDTH-1], base_s} + extend_sample(io_in_bits);
        sat_s     = saturate(sum_s);
        clamp_s   = sat_s[ACC_WIDTH];
        acc_add_s = sat_s[ACC_WIDTH-1:0];
        cnt_inc_s = cnt_r + CNT_ONE;
    end

    // Frame state machine: next state, accumulator, count and overflow.
    always_comb begin
        state_nxt_s = state_r;
        acc_nxt_s   = acc_r;
        cnt_nxt_s   = cnt_r;
        ovf_nxt_s   = ovf_r;
        close_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A flush with no sample is ignored: empty frames are never sent.
                if (accept_s) begin
                    acc_nxt_s = acc_add_s;
                    cnt_nxt_s = CNT_ONE;
                    ovf_nxt_s = clamp_s;
                    if ((CNT_LAST == CNT_ONE) || io_flush) begin
                        close_s     = 1'b1;
                        state_nxt_s = ST_HOLD;
                    end else begin
                        state_nxt_s = ST_ACCUM;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (accept_s) begin
                    acc_nxt_s = acc_add_s;
                    cnt_nxt_s = cnt_inc_s;
                    ovf_nxt_s = ovf_r | clamp_s;
                    if ((cnt_inc_s == CNT_LAST) || io_flush) begin
                        close_s     = 1'b1;
                        state_nxt_s = ST_HOLD;
                    end else begin
                        state_nxt_s = ST_ACCUM;
                    end
                end else if (io_flush) begin
                    // At least one sample is already in the frame here.
                    close_s     = 1'b1;
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (io_out_ready) begin
                    acc_nxt_s   = ACC_ZERO;
                    cnt_nxt_s   = CNT_ZERO;
                    ovf_nxt_s   = 1'b0;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                acc_nxt_s   = ACC_ZERO;
                cnt_nxt_s   = CNT_ZERO;
                ovf_nxt_s   = 1'b0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and frame accumulator registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            acc_r   <= ACC_ZERO;
            cnt_r   <= CNT_ZERO;
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            acc_r   <= acc_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ovf_r   <= ovf_nxt_s;
        end
    end

    // Registered handshake outputs and the frame result latched on entry to HOLD.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_sum_r   <= ACC_ZERO;
            out_count_r <= CNT_ZERO;
            out_ovf_r   <= 1'b0;
        end else begin
            in_ready_r  <= (state_nxt_s != ST_HOLD);
            out_valid_r <= (state_nxt_s == ST_HOLD);
            if (close_s) begin
                out_sum_r   <= acc_nxt_s;
                out_count_r <= cnt_nxt_s;
                out_ovf_r   <= ovf_nxt_s;
            end else begin
                out_sum_r   <= out_sum_r;
                out_count_r <= out_count_r;
                out_ovf_r   <= out_ovf_r;
            end
        end
    end

    assign io_in_ready  = in_ready_r;
    assign io_out_valid = out_valid_r;
    assign io_out_sum   = out_sum_r;
    assign io_out_count = out_count_r;
    assign io_out_ovf   = out_ovf_r;

endmodule

// File: doc/diff_window_accumulator.md
Name: diff_window_accumulator

Overview:
- Downstream consumer of the 16-bit subtractor stage.
- Accepts a stream of two's-complement differences over a valid/ready handshake and accumulates them over a frame of FRAME_LEN samples, or fewer if flushed early.
- Presents one saturated frame sum, sample count and overflow flag per frame over a valid/ready output.
- Used for windowed error/offset measurement after the minus stage.

Parameters:
- WIDTH, 16, input difference width (signed).
- ACC_WIDTH, 24, accumulator/sum width (signed); must be >= WIDTH+1.
- FRAME_LEN, 8, samples per frame; >= 1.
- CNT_W, $clog2(FRAME_LEN+1), width of the count output (derived; not overridden).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- io_in_valid  input  1  difference sample valid.
- io_in_ready  output  1  block can accept a sample.
- io_in_bits  input  WIDTH  signed difference (subtractor io_out).
- io_flush  input  1  close the current frame early.
- io_out_valid  output  1  frame result valid.
- io_out_ready  input  1  downstream accepts the result.
- io_out_sum  output  ACC_WIDTH  signed saturated frame sum.
- io_out_count  output  CNT_W  samples in the frame.
- io_out_ovf  output  1  saturation occurred in this frame (sticky per frame).

Behaviour:
- Reset (reset=0, async): state=IDLE, acc=0, cnt=0, ovf=0; io_out_valid=0, io_out_sum=0, io_out_count=0, io_out_ovf=0.
- io_in_ready=1 in IDLE/ACCUM, 0 in HOLD. Accept = io_in_valid & io_in_ready.
- Arithmetic:
  - io_in_bits sign-extended to ACC_WIDTH+1 and added to acc.
  - Result above 2^(ACC_WIDTH-1)-1 clamps to that value; result below -2^(ACC_WIDTH-1) clamps to that value.
  - Any clamp sets ovf for the frame.
- States:
  - IDLE: acc=0, cnt=0. On accept: acc=sample, cnt=1.
    - If FRAME_LEN==1 or io_flush=1 in the same cycle: -> HOLD.
    - Otherwise: -> ACCUM.
    - io_flush without accept in IDLE is ignored (no empty frames).
  - ACCUM: on accept, acc+=sample and cnt+=1. Close the frame (-> HOLD) when either:
    - the new cnt == FRAME_LEN, or
    - io_flush=1 in that cycle. The sample accepted in the flush cycle is included.
    - io_flush with no accept also closes the frame, since cnt >= 1.
  - HOLD: io_out_sum/count/ovf are registered copies latched on entry and stable while io_out_valid=1. io_out_valid=1 until io_out_ready=1.
    - On that handshake: acc, cnt and ovf are cleared; -> IDLE; io_out_valid=0 next cycle.
    - io_flush and io_in_valid are ignored in HOLD.
- Latency: io_out_valid rises the cycle after the accept/flush that closes the frame.
  - Minimum frame period is FRAME_LEN accept cycles + 1 HOLD cycle (if io_out_ready=1).
  - There is no bypass of the HOLD cycle.
- Output registers retain their last values after the handshake; downstream qualifies them with io_out_valid.
- Reset mid-frame or mid-HOLD: immediate return to reset values; the partial frame is discarded.

Optional Feature:
- DIFF_ACC_ABS_EN defined:
  - Each sample contributes |io_in_bits|, so the frame result is a sum of absolute differences.
  - |-2^(WIDTH-1)| = 2^(WIDTH-1) is represented exactly (WIDTH+1-bit magnitude).
  - Sum is non-negative; saturation is to the positive maximum only.
- DIFF_ACC_ABS_EN undefined: signed accumulation as above.

Test Plan:
- Reset, then 8 back-to-back samples 1,2,...,8 with io_out_ready=1 -> io_out_valid=1 the cycle after the 8th accept, sum=36, count=8, ovf=0. io_in_ready=0 for that one cycle, then 1.
- Samples 100, -300, 50, then io_flush alone -> sum=-150, count=3, ovf=0. A following io_flush in IDLE produces no output.
- Samples 5, 7 with io_flush asserted together with the 7 -> sum=12, count=2.
- io_out_ready=0 for 10 cycles while in HOLD:
  - io_out_sum/count stay stable and io_in_ready=0.
  - io_in_valid pulses are not accepted.
  - Raising io_out_ready gives a single-cycle handshake, then IDLE.
- With ACC_WIDTH=17, eight samples of 32767 -> sum=65535 (clamped), ovf=1. The next frame of eight -1 -> sum=-8, ovf=0.
- Drop reset after 4 accepted samples -> all outputs 0 at once; a fresh frame of eight 1s -> sum=8. With DIFF_ACC_ABS_EN, eight -3 -> sum=24.
